local_inject_controller: RTL and testbench

Sequencing controller for one node's local traffic generator. It produces the cycle timestamp and injection-period reference that the generator consumes, and mirrors the generator's pending-packet count. It gates `packet_wr_en` on credits for the router's local input buffer and stops injection after a fixed packet budget. It sits between the testbench start/stop control and the local generator / local router port of each ring node.

---
 rtl/noc_inject_pkg.sv | 14 +
 rtl/inject_period_counter.sv | 29 ++
 rtl/local_inject_controller.sv | 131 +++++++++++++
 tb/tb_local_inject_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_inject_pkg.sv
// Shared types and widths for the local injection controller.
package noc_inject_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } inject_state_t;

    localparam int TS_W     = 16;  // timestamp / counter width
    localparam int CREDIT_W = 8;   // local-buffer credit width

endpackage

// File: rtl/inject_period_counter.sv
// Compare-and-wrap counter: counts 0..PERIOD-1 while enabled, pulses tick on
// the last count. Synchronous clear has priority over counting.
module inject_period_counter #(
    parameter int PERIOD = 2,
    parameter int W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tick
);

    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    // Period position: reset by compare rather than modulo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/local_inject_controller.sv
// Sequencing controller for one node's local traffic generator: timestamp,
// injection-period reference, pending mirror, credit gating and packet budget.
// Optional stall counter output is built when INJECT_STALL_CNT_EN is defined.
module local_inject_controller
    import noc_inject_pkg::*;
#(
    parameter int NUM_PACKETS_PER_NODE = 20,
    parameter int INJECT_CYCLE         = 2,
    parameter int BUFFER_SIZE          = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                credit_return,
    output logic [TS_W-1:0]     clk_counter,
    output logic [TS_W-1:0]     inject_clk_ref,
    output logic                packet_wr_en,
    output logic [CREDIT_W-1:0] credits,
    output logic [TS_W-1:0]     issued_cnt,
    output logic                busy,
    output logic                done,
    output logic                credit_err
`ifdef INJECT_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    localparam logic [TS_W-1:0]     BUDGET   = TS_W'(NUM_PACKETS_PER_NODE);
    localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(BUFFER_SIZE);

    inject_state_t   state, state_nxt;
    logic [TS_W-1:0] pending;
    logic            start_acc;
    logic            run;
    logic            tick;
    logic            overflow;

    assign start_acc = start && (state == IDLE || state == DONE);
    assign run       = (state == RUN);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign overflow  = credit_return && !packet_wr_en && (credits == CRED_MAX);

    // Everything here is a register, so wr_en has no path from the inputs.
    assign packet_wr_en = run && (pending != '0) && (credits != '0) &&
                          (issued_cnt < BUDGET);

    inject_period_counter #(
        .PERIOD (INJECT_CYCLE),
        .W      (TS_W)
    ) u_period (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .clr   (start_acc),
        .cnt   (inject_clk_ref),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start only accepted when idle or finished.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issued_cnt >= BUDGET) state_nxt = DRAIN;
            DRAIN:   if (credits == CRED_MAX) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Run timestamp, pending mirror and issue count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_counter <= '0;
            pending     <= '0;
            issued_cnt  <= '0;
        end else if (start_acc) begin
            clk_counter <= '0;
            pending     <= '0;
            issued_cnt  <= '0;
        end else begin
            if (busy) clk_counter <= clk_counter + TS_W'(1);
            case ({tick, packet_wr_en})
                2'b10:   pending <= pending + TS_W'(1);
                2'b01:   pending <= pending - TS_W'(1);
                default: pending <= pending;
            endcase
            // wr_en is already gated by the budget, so this saturates.
            if (packet_wr_en) issued_cnt <= issued_cnt + TS_W'(1);
        end
    end

    // Credits track free local-buffer slots in every state; a start does not
    // reload them because flits from a previous run may still be in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            credits <= CRED_MAX;
        else if (packet_wr_en && !credit_return)
            credits <= credits - CREDIT_W'(1);
        else if (credit_return && !packet_wr_en && !overflow)
            credits <= credits + CREDIT_W'(1);
    end

    // Sticky overflow flag, cleared only by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         credit_err <= 1'b0;
        else if (start_acc) credit_err <= 1'b0;
        else if (overflow)  credit_err <= 1'b1;
    end

`ifdef INJECT_STALL_CNT_EN
    // Cycles where a packet is owed but the router buffer is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (start_acc)
            stall_cycles <= '0;
        else if (run && (pending != '0) && (credits == '0) && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_local_inject_controller.sv
// Directed bench: three controller instances with different parameters.
module tb_local_inject_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A: IC=2, BUF=4, budget 20
    logic        start_a = 0, cr_a = 0;
    logic [15:0] cc_a, ref_a, iss_a;
    logic        wr_a, busy_a, done_a, err_a;
    logic [7:0]  cred_a;
    // B: IC=2, BUF=2, budget 20
    logic        start_b = 0, cr_b = 0;
    logic [15:0] cc_b, ref_b, iss_b;
    logic        wr_b, busy_b, done_b, err_b;
    logic [7:0]  cred_b;
    // C: IC=1, BUF=4, budget 3
    logic        start_c = 0, cr_c = 0;
    logic [15:0] cc_c, ref_c, iss_c;
    logic        wr_c, busy_c, done_c, err_c;
    logic [7:0]  cred_c;
`ifdef INJECT_STALL_CNT_EN
    logic [31:0] stall_a, stall_b, stall_c;
`endif

    local_inject_controller #(.NUM_PACKETS_PER_NODE(20), .INJECT_CYCLE(2), .BUFFER_SIZE(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .credit_return(cr_a),
        .clk_counter(cc_a), .inject_clk_ref(ref_a), .packet_wr_en(wr_a), .credits(cred_a),
        .issued_cnt(iss_a), .busy(busy_a), .done(done_a), .credit_err(err_a)
`ifdef INJECT_STALL_CNT_EN
        , .stall_cycles(stall_a)
`endif
    );

    local_inject_controller #(.NUM_PACKETS_PER_NODE(20), .INJECT_CYCLE(2), .BUFFER_SIZE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .credit_return(cr_b),
        .clk_counter(cc_b), .inject_clk_ref(ref_b), .packet_wr_en(wr_b), .credits(cred_b),
        .issued_cnt(iss_b), .busy(busy_b), .done(done_b), .credit_err(err_b)
`ifdef INJECT_STALL_CNT_EN
        , .stall_cycles(stall_b)
`endif
    );

    local_inject_controller #(.NUM_PACKETS_PER_NODE(3), .INJECT_CYCLE(1), .BUFFER_SIZE(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .credit_return(cr_c),
        .clk_counter(cc_c), .inject_clk_ref(ref_c), .packet_wr_en(wr_c), .credits(cred_c),
        .issued_cnt(iss_c), .busy(busy_c), .done(done_c), .credit_err(err_c)
`ifdef INJECT_STALL_CNT_EN
        , .stall_cycles(stall_c)
`endif
    );

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        st;
        logic        cr;
        logic [15:0] cc;
        logic [15:0] rf;
        logic        wr;
        logic [7:0]  cred;
        logic [15:0] iss;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic cr, input int cc, input int rf,
                                input logic wr, input int cred, input int iss,
                                input logic busy, input logic done, input logic err);
        vec_t v;
        v.st = st; v.cr = cr; v.cc = 16'(cc); v.rf = 16'(rf); v.wr = wr;
        v.cred = 8'(cred); v.iss = 16'(iss); v.busy = busy; v.done = done; v.err = err;
        return v;
    endfunction

    initial begin
        logic [2:0] hist;
        int pulses, min_cred, last_ret, done_at, guard;
        logic ign_pend, ign_done;
        logic [15:0] cc_prev;

        // B: reset state, IDLE overflow, then credit starvation and recovery.
        //                st cr  cc rf wr cr is bsy dn err
        vecs.push_back(mk(0, 0,  0, 0, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 0, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0,  0, 0, 0, 2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,  1, 1, 0, 2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,  2, 0, 1, 2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,  3, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,  4, 0, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,  5, 1, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0,  6, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0,  7, 1, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0,  8, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1,  9, 1, 1, 1, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 10, 0, 0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 11, 1, 0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 12, 0, 1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 13, 1, 1, 1, 4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 14, 0, 0, 0, 5, 1, 0, 0));

        #22 rst_n = 1'b1;

        foreach (vecs[i]) begin
            start_b = vecs[i].st;
            cr_b    = vecs[i].cr;
            @(posedge clk); #1;
            chk($sformatf("b%0d_clk_counter", i), cc_b,   vecs[i].cc);
            chk($sformatf("b%0d_ref", i),         ref_b,  vecs[i].rf);
            chk($sformatf("b%0d_wr_en", i),       wr_b,   vecs[i].wr);
            chk($sformatf("b%0d_credits", i),     cred_b, vecs[i].cred);
            chk($sformatf("b%0d_issued", i),      iss_b,  vecs[i].iss);
            chk($sformatf("b%0d_busy", i),        busy_b, vecs[i].busy);
            chk($sformatf("b%0d_done", i),        done_b, vecs[i].done);
            chk($sformatf("b%0d_err", i),         err_b,  vecs[i].err);
        end
        start_b = 0; cr_b = 0;
`ifdef INJECT_STALL_CNT_EN
        chk("b_stall_cycles", stall_b, 32'd5);
`endif

        // C: INJECT_CYCLE=1, budget 3 -> pulses on samples 1..3 after start.
        start_c = 1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            start_c = 0;
            chk($sformatf("c%0d_wr_en", k), wr_c, (k >= 1 && k <= 3) ? 1 : 0);
            chk($sformatf("c%0d_ref", k),   ref_c, 0);
        end
        chk("c_issued", iss_c, 3);
        chk("c_credits", cred_c, 1);
        cr_c = 1;
        repeat (3) begin @(posedge clk); #1; end
        cr_c = 0;
        chk("c_credits_full", cred_c, 4);
        chk("c_done_not_yet", done_c, 0);
        @(posedge clk); #1;
        chk("c_done", done_c, 1);

        // A: full run, returns are wr_en delayed by 3 cycles, start at cycle 5.
        repeat (5) begin @(posedge clk); #1; end
        hist = 3'b000; pulses = 0; min_cred = 255; last_ret = -1; done_at = -1;
        ign_pend = 0; ign_done = 0; cc_prev = 0;
        start_a = 1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            if (ign_pend) begin
                chk("a_start_ignored_cc", cc_a, cc_prev + 16'd1);
                chk("a_start_ignored_busy", busy_a, 1);
                ign_pend = 0;
            end
            start_a = 0;
            if (wr_a) pulses++;
            if (busy_a && int'(cred_a) < min_cred) min_cred = int'(cred_a);
            if (done_a) begin done_at = cyc; break; end
            cr_a = hist[2];
            if (cr_a) last_ret = cyc;
            hist = {hist[1:0], wr_a};
            if (!ign_done && iss_a == 16'd5 && busy_a) begin
                start_a = 1; cc_prev = cc_a; ign_pend = 1; ign_done = 1;
            end
        end
        cr_a = 0; hist = 3'b000;
        chk("a_done_reached", (done_at >= 0) ? 1 : 0, 1);
        chk("a_pulses", pulses, 20);
        chk("a_issued", iss_a, 20);
        chk("a_credits_never_zero", (min_cred > 0) ? 1 : 0, 1);
        chk("a_done_after_last_return", done_at, last_ret + 2);
        chk("a_credit_err", err_a, 0);
        chk("a_credits_final", cred_a, 4);

        // A: restart from DONE, reset asynchronously with issued_cnt=7.
        start_a = 1;
        guard = 0;
        while (iss_a != 16'd7 && guard < 100) begin
            @(posedge clk); #1;
            start_a = 0;
            cr_a = hist[2];
            hist = {hist[1:0], wr_a};
            guard++;
        end
        start_a = 0;
        chk("a_reached_issued7", iss_a, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_clk_counter", cc_a, 0);
        chk("rst_ref", ref_a, 0);
        chk("rst_wr_en", wr_a, 0);
        chk("rst_credits", cred_a, 4);
        chk("rst_issued", iss_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        cr_a = 0; hist = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        chk("restart_clk_counter0", cc_a, 0);
        chk("restart_busy", busy_a, 1);
        @(posedge clk); #1;
        chk("restart_clk_counter1", cc_a, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
